seq_alu_exec: RTL and testbench

Sequential execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two operands. Single-cycle codes (add/sub/logic/shift/compare) complete in one cycle. Multiply and divide codes run iteratively over WIDTH cycles. A start/busy/done handshake lets the datapath stall while a multi-cycle operation is in flight.

---
 rtl/seq_alu_exec.sv | 211 +++++++++++++++++++++
 tb/tb_seq_alu_exec.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_exec.sv
// -----------------------------------------------------------------------------
// seq_alu_exec
// Sequential execution unit driven by a 4-bit ALU control code.
// Single-cycle codes (add/sub/logic/shift/compare) finish one cycle after
// acceptance. MUL (shift-add) and, when enabled, DIV (restoring) iterate for
// WIDTH cycles. A start/busy/done handshake lets the datapath stall.
//
// Optional feature macro: SEQ_ALU_DIV_EN
//   defined   : code 9 runs the iterative unsigned divider
//               (divide by zero returns all ones after one cycle)
//   undefined : no divider hardware; code 9 returns 0 like codes 10-15
//
// Ports:
//   inp_clk         clock, rising edge
//   inp_rst_n       asynchronous active-low reset
//   inp_start       operation request, sampled only while idle
//   inp_aluControl  4-bit operation code
//   inp_a, inp_b    WIDTH-bit operands
//   out_result      registered result, holds until the next completion
//   out_zero        registered flag, 1 when out_result == 0
//   out_done        one-cycle pulse, result valid this cycle
//   out_busy        high while an operation is in flight (incl. done cycle)
// -----------------------------------------------------------------------------
module seq_alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             inp_clk,
  input  logic             inp_rst_n,
  input  logic             inp_start,
  input  logic [3:0]       inp_aluControl,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_done,
  output logic             out_busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  // r_a: multiplicand (MUL) or dividend/quotient shift register (DIV)
  // r_b: multiplier (MUL) or divisor (DIV)
  // r_acc: product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_go_run;
  logic             w_last;
  logic [WIDTH-1:0] w_single;
  logic             w_slt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_run_res;
  logic [WIDTH-1:0] w_mul_acc;

`ifdef SEQ_ALU_DIV_EN
  logic             r_is_div;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
`endif

  assign w_accept = (r_state == S_IDLE) && inp_start;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_slt    = ($signed(inp_a) < $signed(inp_b));

`ifdef SEQ_ALU_DIV_EN
  assign w_go_run = (inp_aluControl == 4'd8) ||
                    ((inp_aluControl == 4'd9) && (inp_b != {WIDTH{1'b0}}));
`else
  assign w_go_run = (inp_aluControl == 4'd8);
`endif

  // Result of every operation that completes without an iterative phase
  always_comb begin
    w_single = {WIDTH{1'b0}};
    case (inp_aluControl)
      4'd0:    w_single = inp_a + inp_b;
      4'd1:    w_single = inp_a - inp_b;
      4'd2:    w_single = inp_a & inp_b;
      4'd3:    w_single = inp_a | inp_b;
      4'd4:    w_single = inp_a ^ inp_b;
      4'd5:    w_single = inp_a << inp_b[CW-1:0];
      4'd6:    w_single = inp_a >> inp_b[CW-1:0];
      4'd7:    w_single = {{(WIDTH-1){1'b0}}, w_slt};
`ifdef SEQ_ALU_DIV_EN
      // Only reached here when the divisor is zero
      4'd9:    w_single = {WIDTH{1'b1}};
`endif
      default: w_single = {WIDTH{1'b0}};
    endcase
  end

  assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

`ifdef SEQ_ALU_DIV_EN
  // Shift the next dividend bit into the remainder, then trial-subtract
  assign w_div_shift = {r_acc, r_a[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_b};
`endif

  // One iteration step of the multiplier or divider
  always_comb begin
    w_a_nxt   = r_a << 1;
    w_b_nxt   = r_b >> 1;
    w_acc_nxt = w_mul_acc;
    w_run_res = w_mul_acc;
`ifdef SEQ_ALU_DIV_EN
    if (r_is_div) begin
      w_b_nxt = r_b;
      if (w_div_trial[WIDTH] == 1'b0) begin
        w_acc_nxt = w_div_trial[WIDTH-1:0];
        w_a_nxt   = {r_a[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_div_shift[WIDTH-1:0];
        w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
      end
      w_run_res = w_a_nxt;
    end else begin
      w_run_res = w_mul_acc;
    end
`endif
  end

  // State register
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_go_run ? S_RUN : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latching, iteration datapath and registered outputs
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      r_cnt      <= {CW{1'b0}};
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_acc      <= {WIDTH{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      r_is_div   <= 1'b0;
`endif
      out_result <= {WIDTH{1'b0}};
      out_zero   <= 1'b0;
      out_done   <= 1'b0;
      out_busy   <= 1'b0;
    end else begin
      // done/busy are registered copies of the upcoming state
      out_done <= (w_state_nxt == S_DONE);
      out_busy <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_a   <= inp_a;
        r_b   <= inp_b;
        r_acc <= {WIDTH{1'b0}};
        r_cnt <= {CW{1'b0}};
`ifdef SEQ_ALU_DIV_EN
        r_is_div <= (inp_aluControl == 4'd9);
`endif
        if (!w_go_run) begin
          out_result <= w_single;
          out_zero   <= (w_single == {WIDTH{1'b0}});
        end
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        r_a   <= w_a_nxt;
        r_b   <= w_b_nxt;
        r_acc <= w_acc_nxt;
        if (w_last) begin
          out_result <= w_run_res;
          out_zero   <= (w_run_res == {WIDTH{1'b0}});
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_exec.sv
module tb_seq_alu_exec;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    code;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  result;
  logic          zero;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Bench-side record of what the result outputs should currently hold
  logic [W-1:0]  m_result;
  logic          m_zero;

  seq_alu_exec #(.WIDTH(W)) dut (
    .inp_clk        (clk),
    .inp_rst_n      (rst_n),
    .inp_start      (start),
    .inp_aluControl (code),
    .inp_a          (a),
    .inp_b          (b),
    .out_result     (result),
    .out_zero       (zero),
    .out_done       (done),
    .out_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned ux;
    int unsigned uy;
    int sx;
    int sy;
    longint unsigned p;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    case (c)
      4'd0: return W'((ux + uy) % 65536);
      4'd1: return W'((ux + 65536 - uy) % 65536);
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return W'((ux * (1 << (uy % 16))) % 65536);
      4'd6: return W'(ux / (1 << (uy % 16)));
      4'd7: return (sx < sy) ? 16'd1 : 16'd0;
      4'd8: begin
        p = longint'(ux) * longint'(uy);
        return W'(p % 65536);
      end
`ifdef SEQ_ALU_DIV_EN
      4'd9: return (uy == 0) ? 16'hFFFF : W'(ux / uy);
`endif
      default: return 16'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [W-1:0] y);
    if (c == 4'd8) return W + 1;
`ifdef SEQ_ALU_DIV_EN
    if (c == 4'd9 && y != 16'd0) return W + 1;
`endif
    return 1;
  endfunction

  // Issue one operation; optionally pulse a stray ADD start at cycle pulse_at
  task automatic do_op(input string tag, input logic [3:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int pulse_at);
    int lat;
    int got;
    logic [W-1:0] exp;
    lat = ref_lat(c, y);
    exp = ref_res(c, x, y);
    got = 0;
    @(negedge clk);
    code = c; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    code = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == pulse_at) begin
        start = 1'b1; code = 4'd0; a = 16'd1; b = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        got = k;
        break;
      end
      check({tag, "_busy_run"}, busy, 1'b1);
      check({tag, "_hold"}, result, m_result);
    end
    check({tag, "_latency"}, got, lat);
    m_result = exp;
    m_zero   = (exp == 16'd0);
    check({tag, "_result"}, result, m_result);
    check({tag, "_zero"}, zero, m_zero);
    check({tag, "_busy_done"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_clear"}, busy, 1'b0);
    check({tag, "_stable"}, result, m_result);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; code = 4'd0; a = 16'd0; b = 16'd0;
    m_result = 16'd0; m_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 16'd0);
    check("rst_zero", zero, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 0);
    do_op("sub_eq",  4'd1, 16'h1234, 16'h1234, 0);
    do_op("slt_neg", 4'd7, 16'hFFFF, 16'h0001, 0);
    do_op("srl_3",   4'd6, 16'h8000, 16'h0013, 0);
    do_op("sll_15",  4'd5, 16'h0003, 16'h00FF, 0);
    do_op("mul_ign", 4'd8, 16'd300,  16'd200,  5);
    do_op("div_7",   4'd9, 16'd1000, 16'd7,    0);
    do_op("div_0",   4'd9, 16'd5,    16'd0,    0);
    do_op("div_max", 4'd9, 16'hFFFF, 16'h0001, 0);
    do_op("code_12", 4'd12, 16'h1111, 16'h2222, 0);
    do_op("mul_max", 4'd8, 16'hFFFF, 16'hFFFF, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    code = 4'd8; a = 16'd300; b = 16'd200; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", result, 16'd0);
    check("mid_rst_zero", zero, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_result = 16'd0; m_zero = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("mid_no_done", done, 1'b0);
    end
    do_op("add_after_rst", 4'd0, 16'd2, 16'd3, 0);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [3:0] rc;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rc = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'd0;
        1:       rb = W'($urandom_range(1, 20));
        default: rb = W'($urandom);
      endcase
      do_op("rand", rc, ra, rb, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
